// File: rtl/sync_debounce.sv
// sync_debounce: STAGES-deep synchronizer followed by a DEBOUNCE-clock
// stability filter.
//
// Ports:
//   clk        system clock
//   rst        async active-high reset
//   in         raw asynchronous level
//   level      debounced, synchronized level (registered)
//   rise       one-cycle pulse on the edge level goes 0->1
//   fall       one-cycle pulse on the edge level goes 1->0
//   glitch_cnt saturating count of rejected glitches (GLITCH_CNT_EN only)
//
// Optional feature macro: GLITCH_CNT_EN
module sync_debounce #(
  parameter int STAGES   = 2,
  parameter int DEBOUNCE = 10,
  parameter int CNT_W    = 4,
  parameter int GLITCH_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic level,
  output logic rise,
  output logic fall
`ifdef GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  if (STAGES < 2 || DEBOUNCE < 1 || GLITCH_W < 1 ||
      (2 ** CNT_W) < DEBOUNCE) begin : g_bad_param
    $error("sync_debounce: illegal parameters");
  end

  logic [STAGES-1:0] sync_q;
  logic              sync_out;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              level_q, level_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              mismatch;
  logic              flip;

  assign sync_out = sync_q[STAGES-1];
  assign mismatch = sync_out != level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], in};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flip    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mismatch) begin
          // A single mismatching edge is enough when DEBOUNCE is 1.
          if (DEBOUNCE == 1) begin
            flip = 1'b1;
          end else begin
            state_d = CHECK;
            cnt_d   = ONE;
          end
        end
      end
      CHECK: begin
        if (mismatch) begin
          if (cnt_q == LAST) begin
            flip    = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end else begin
          // Input returned before the window closed: glitch.
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    level_d = flip ? sync_out : level_q;
    rise_d  = flip & sync_out;
    fall_d  = flip & ~sync_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

`ifdef GLITCH_CNT_EN
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic                reject;

  assign reject = (state_q == CHECK) && !mismatch;

  always_comb begin
    glitch_d = glitch_q;
    // Saturate rather than wrap.
    if (reject && (glitch_q != '1)) begin
      glitch_d = glitch_q + GLITCH_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      glitch_q <= '0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// tb_sync_debounce: directed checks of sync_debounce (defaults) and of a
// DEBOUNCE=1, STAGES=3 instance.
module tb_sync_debounce;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic din2 = 1'b0;
  logic lvl, rs, fl;
  logic lvl2, rs2, fl2;
`ifdef GLITCH_CNT_EN
  logic [7:0] gc;
  logic [7:0] gc2;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sync_debounce u_dut (
    .clk   (clk),
    .rst   (rst),
    .in    (din),
    .level (lvl),
    .rise  (rs),
    .fall  (fl)
`ifdef GLITCH_CNT_EN
    ,
    .glitch_cnt (gc)
`endif
  );

  sync_debounce #(
    .STAGES   (3),
    .DEBOUNCE (1),
    .CNT_W    (1)
  ) u_d1 (
    .clk   (clk),
    .rst   (rst),
    .in    (din2),
    .level (lvl2),
    .rise  (rs2),
    .fall  (fl2)
`ifdef GLITCH_CNT_EN
    ,
    .glitch_cnt (gc2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk3(input string tag, input logic l, input logic r,
                      input logic f);
    chk({tag, ".level"}, 32'(lvl), 32'(l));
    chk({tag, ".rise"}, 32'(rs), 32'(r));
    chk({tag, ".fall"}, 32'(fl), 32'(f));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset held with in=1
    din = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk3("rst", 1'b0, 1'b0, 1'b0);
`ifdef GLITCH_CNT_EN
      chk("rst.gc", 32'(gc), 32'd0);
`endif
    end
    @(negedge clk);
    din = 1'b0;
    rst = 1'b0;
    repeat (4) tick();

    // 2: clean rise, level at k+11
    @(negedge clk);
    din = 1'b1;
    for (int n = 0; n <= 20; n++) begin
      tick();
      chk3($sformatf("rise%0d", n), n >= 11, n == 11, 1'b0);
    end

    // 3: clean fall
    @(negedge clk);
    din = 1'b0;
    for (int n = 0; n <= 20; n++) begin
      tick();
      chk3($sformatf("fall%0d", n), n < 11, 1'b0, n == 11);
    end

    // 4: 5-clock glitch is rejected
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      din = (n < 5);
      tick();
      chk3($sformatf("gl%0d", n), 1'b0, 1'b0, 1'b0);
    end
`ifdef GLITCH_CNT_EN
    chk("gl.cnt1", 32'(gc), 32'd1);
    for (int g = 0; g < 299; g++) begin
      @(negedge clk);
      din = 1'b1;
      repeat (5) @(negedge clk);
      din = 1'b0;
      repeat (6) @(negedge clk);
    end
    tick();
    chk("gl.sat", 32'(gc), 32'd255);
    chk3("gl.sat", 1'b0, 1'b0, 1'b0);
`endif

    // 5a: reset mid-CHECK while level=0
    @(negedge clk);
    din = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk3("mrst0", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n <= 14; n++) begin
      tick();
      chk3($sformatf("mrel%0d", n), n >= 11, n == 11, 1'b0);
    end

    // 5b: reset mid-CHECK while level=1 drops it with no fall pulse
    @(negedge clk);
    din = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    chk3("mrst1.pre", 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk3("mrst1", 1'b0, 1'b0, 1'b0);
    tick();
    chk3("mrst1.hold", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n <= 14; n++) begin
      tick();
      chk3($sformatf("mrel1_%0d", n), 1'b0, 1'b0, 1'b0);
    end

    // 6: DEBOUNCE=1, STAGES=3 -> flip at k+3
    @(negedge clk);
    din2 = 1'b1;
    for (int n = 0; n <= 6; n++) begin
      tick();
      chk($sformatf("d1r%0d.level", n), 32'(lvl2), 32'(n >= 3));
      chk($sformatf("d1r%0d.rise", n), 32'(rs2), 32'(n == 3));
      chk($sformatf("d1r%0d.fall", n), 32'(fl2), 32'd0);
    end
    @(negedge clk);
    din2 = 1'b0;
    for (int n = 0; n <= 6; n++) begin
      tick();
      chk($sformatf("d1f%0d.level", n), 32'(lvl2), 32'(n < 3));
      chk($sformatf("d1f%0d.fall", n), 32'(fl2), 32'(n == 3));
      chk($sformatf("d1f%0d.rise", n), 32'(rs2), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
